fminmax_reduce_ctrl: RTL and testbench

//  Sequencing controller for FP32 min/max reduction over a streamed vector.

---
 rtl/fp32_pkg.sv | 19 +
 rtl/fp32_cmp.sv | 53 +++++
 rtl/fminmax_reduce_ctrl.sv | 131 +++++++++++++
 tb/tb_fminmax_reduce_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared FP32 types and constants for the min/max reduction controller.
package fp32_pkg;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] mant;
   } fp32_t;

   localparam logic [31:0] FP32_QNAN    = 32'hFFC00000;
   localparam logic [7:0]  FP32_EXP_MAX = 8'hFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/fp32_cmp.sv
// Combinational FP32 compare core: decides whether operand b replaces the
// accumulator a under min/max ordering, and flags NaN on either side.
// Zeros of either sign compare equal; equal values never replace.
module fp32_cmp
   import fp32_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        op_max,
   output logic        take_b,
   output logic        is_nan
);

   fp32_t fa;
   fp32_t fb;
   logic  a_nan;
   logic  b_nan;
   logic  both_zero;
   logic  b_gt_a;
   logic  a_gt_b;

   assign fa = fp32_t'(a);
   assign fb = fp32_t'(b);

   // Classify operands and order them by sign, then exponent/mantissa magnitude.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
      take_b    = 1'b0;
      is_nan    = 1'b0;
      b_gt_a    = 1'b0;
      a_gt_b    = 1'b0;
      a_nan     = (fa.exp == FP32_EXP_MAX) && (fa.mant != '0);
      b_nan     = (fb.exp == FP32_EXP_MAX) && (fb.mant != '0);
      both_zero = (a[30:0] == '0) && (b[30:0] == '0);

      if (a_nan || b_nan) begin
         is_nan = 1'b1;
      end else if (!both_zero) begin
         if (fa.sign != fb.sign) begin
            b_gt_a = !fb.sign;
            a_gt_b = !fa.sign;
         end else if (!fa.sign) begin
            b_gt_a = {fb.exp, fb.mant} > {fa.exp, fa.mant};
            a_gt_b = {fa.exp, fa.mant} > {fb.exp, fb.mant};
         end else begin
            b_gt_a = {fb.exp, fb.mant} < {fa.exp, fa.mant};
            a_gt_b = {fa.exp, fa.mant} < {fb.exp, fb.mant};
         end
         take_b = op_max ? b_gt_a : a_gt_b;
      end
   end

endmodule

// File: rtl/fminmax_reduce_ctrl.sv
// Sequencing controller for FP32 min/max reduction over a streamed vector.
// Optional feature macro: FMINMAX_INDEX_EN adds the res_idx port and the
// element position counter that tracks the winning element.
module fminmax_reduce_ctrl
   import fp32_pkg::*;
#(
   parameter  int MAX_LEN = 64,
   localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             op_max,
   output logic             busy,
   input  logic             in_valid,
   input  logic [31:0]      in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [31:0]      out_data,
   output logic             out_nan,
   input  logic             out_ready
`ifdef FMINMAX_INDEX_EN
   ,
   output logic [LEN_W-1:0] res_idx
`endif
);

   state_t           state;
   state_t           state_nx;
   logic [LEN_W-1:0] len_sat;
   logic [LEN_W-1:0] remaining;
   logic             first;
   logic             op_max_r;
   logic [31:0]      acc;
   logic             nan_flag;
   logic             accept;
   logic             take_b;
   logic             cmp_nan;
`ifdef FMINMAX_INDEX_EN
   logic [LEN_W-1:0] pos;
   logic [LEN_W-1:0] idx_r;
`endif

   assign len_sat = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
   assign accept  = in_valid && in_ready;

   fp32_cmp u_cmp (
      .a      (acc),
      .b      (in_data),
      .op_max (op_max_r),
      .take_b (take_b),
      .is_nan (cmp_nan)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: non-blocking assignments make every register update from pre-edge values, independent of block order.
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state decode.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (start) state_nx = (len_sat == '0) ? DONE : ACC;
         ACC:  if (accept && (remaining == LEN_W'(1))) state_nx = DONE;
         DONE: if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Handshake outputs decoded from state alone.
   always_comb begin
      busy      = (state == ACC) || (state == DONE);
      in_ready  = (state == ACC);
      out_valid = (state == DONE);
   end

   // Accumulator, NaN flag, element counters; first element loads unconditionally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         remaining <= '0;
         first     <= 1'b0;
         op_max_r  <= 1'b0;
         acc       <= '0;
         nan_flag  <= 1'b0;
`ifdef FMINMAX_INDEX_EN
         pos       <= '0;
         idx_r     <= '0;
`endif
      end else if ((state == IDLE) && start) begin
         remaining <= len_sat;
         first     <= 1'b1;
         op_max_r  <= op_max;
         acc       <= '0;
         nan_flag  <= 1'b0;
`ifdef FMINMAX_INDEX_EN
         pos       <= '0;
         idx_r     <= '0;
`endif
      end else if (accept) begin
         remaining <= remaining - LEN_W'(1);
         first     <= 1'b0;
`ifdef FMINMAX_INDEX_EN
         pos       <= pos + LEN_W'(1);
`endif
         if (cmp_nan) begin
            // Once NaN, acc is the canonical qNaN and stays so; the stream keeps draining.
            acc      <= FP32_QNAN;
            nan_flag <= 1'b1;
`ifdef FMINMAX_INDEX_EN
            if (!nan_flag) idx_r <= pos;
`endif
         end else if (first || take_b) begin
            acc <= in_data;
`ifdef FMINMAX_INDEX_EN
            idx_r <= pos;
`endif
         end
      end
   end

   assign out_data = acc;
   assign out_nan  = nan_flag;
`ifdef FMINMAX_INDEX_EN
   assign res_idx  = idx_r;
`endif

endmodule

// File: tb/tb_fminmax_reduce_ctrl.sv
// Self-checking bench for fminmax_reduce_ctrl: directed vector table,
// hand-written handshake/reset sequences, and randomized reductions
// compared against a real-valued reference model.
module tb_fminmax_reduce_ctrl;

   localparam int MAX_LEN = 64;
   localparam int LEN_W   = 7;
   localparam logic [31:0] QNAN = 32'hFFC00000;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [LEN_W-1:0] len;
   logic             op_max;
   logic             busy;
   logic             in_valid;
   logic [31:0]      in_data;
   logic             in_ready;
   logic             out_valid;
   logic [31:0]      out_data;
   logic             out_nan;
   logic             out_ready;
`ifdef FMINMAX_INDEX_EN
   logic [LEN_W-1:0] res_idx;
`endif

   int checks   = 0;
   int failures = 0;
   logic [31:0] elems[$];

   fminmax_reduce_ctrl #(.MAX_LEN(MAX_LEN)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len       (len),
      .op_max    (op_max),
      .busy      (busy),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_nan   (out_nan),
      .out_ready (out_ready)
`ifdef FMINMAX_INDEX_EN
      ,
      .res_idx   (res_idx)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic bit word_is_nan(input logic [31:0] w);
      return (w[30:23] == 8'hFF) && (w[22:0] != 23'd0);
   endfunction

   function automatic real to_real(input logic [31:0] w);
      int  e;
      real m;
      real mag;
      e = int'(w[30:23]);
      m = real'(int'(w[22:0]));
      if (e == 0)        mag = m * (2.0 ** (-149));
      else if (e == 255) mag = 1.0e300;
      else               mag = (1.0 + m / 8388608.0) * (2.0 ** (e - 127));
      return w[31] ? -mag : mag;
   endfunction

   task automatic model(input bit op, input int n, output logic [31:0] data,
                        output bit nan, output int idx);
      int best = 0;
      int nan_i = 0;
      nan = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (word_is_nan(elems[i])) begin
            if (!nan) nan_i = i;
            nan = 1'b1;
         end else if (!nan && i > 0) begin
            if (op ? (to_real(elems[i]) > to_real(elems[best]))
                   : (to_real(elems[i]) < to_real(elems[best])))
               best = i;
         end
      end
      data = nan ? QNAN : ((n == 0) ? 32'h0 : elems[best]);
      idx  = nan ? nan_i : best;
   endtask

   // ---------------- one complete reduction ----------------
   task automatic run_op(input string tag, input bit op, input int n_len, input bit gaps,
                         input int ready_delay, input bit poke_start,
                         input logic [31:0] exp_data, input bit exp_nan, input int exp_idx);
      int n_eff;
      int k = 0;
      int cyc = 0;
      bit last_acc = 1'b0;
      n_eff = (n_len > MAX_LEN) ? MAX_LEN : n_len;
      @(posedge clk); #1;
      start = 1'b1; op_max = op; len = LEN_W'(n_len);
      @(posedge clk); #1;
      start = 1'b0;
      while (!out_valid && cyc < 4 * n_eff + 20) begin
         last_acc = 1'b0;
         in_valid = in_ready && (!gaps || ($urandom % 3 != 0));
         in_data  = (k < elems.size()) ? elems[k] : 32'hDEADBEEF;
         if (in_valid && in_ready) begin
            k++;
            last_acc = 1'b1;
         end
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0;
      check({tag, " out_valid"}, 32'(out_valid), 32'd1);
      if (n_eff == 0) check({tag, " zero-len latency"}, cyc, 0);
      else            check({tag, " latency"}, 32'(last_acc), 32'd1);
      check({tag, " accepts"}, k, n_eff);
      check({tag, " in_ready in DONE"}, 32'(in_ready), 32'd0);
      check({tag, " busy in DONE"}, 32'(busy), 32'd1);
      check({tag, " out_data"}, out_data, exp_data);
      check({tag, " out_nan"}, 32'(out_nan), 32'(exp_nan));
`ifdef FMINMAX_INDEX_EN
      check({tag, " res_idx"}, 32'(res_idx), exp_idx);
`endif
      for (int d = 0; d < ready_delay; d++) begin
         if (poke_start) begin
            start = d[0]; len = LEN_W'(2);
         end
         in_valid = d[0];
         @(posedge clk); #1;
         check({tag, " hold valid"}, 32'(out_valid), 32'd1);
         check({tag, " hold data"}, out_data, exp_data);
         check({tag, " hold nan"}, 32'(out_nan), 32'(exp_nan));
      end
      in_valid  = 1'b0;
      start     = poke_start;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      start     = 1'b0;
      check({tag, " released"}, 32'(out_valid), 32'd0);
      check({tag, " idle busy"}, 32'(busy), 32'd0);
      if (poke_start) begin
         repeat (3) @(posedge clk);
         #1;
         check({tag, " no second result"}, 32'(out_valid), 32'd0);
         check({tag, " stays idle"}, 32'(busy | in_ready), 32'd0);
      end
   endtask

   typedef struct {
      bit          op;
      int          n;
      logic [31:0] d[4];
      logic [31:0] exp_data;
      bit          exp_nan;
      int          exp_idx;
   } vec_t;

   vec_t vecs[8];

   initial begin
      logic [31:0] m_data;
      bit          m_nan;
      int          m_idx;

      vecs[0] = '{0, 3, '{32'h40400000, 32'hBFC00000, 32'h40000000, 32'h0}, 32'hBFC00000, 0, 1};
      vecs[1] = '{1, 2, '{32'h80000000, 32'h00000000, 32'h0, 32'h0}, 32'h80000000, 0, 0};
      vecs[2] = '{0, 3, '{32'h3F800000, 32'h7FC00001, 32'h00000000, 32'h0}, QNAN, 1, 1};
      vecs[3] = '{1, 4, '{32'h3F800000, 32'h7F800000, 32'h40000000, 32'hC0000000}, 32'h7F800000, 0, 1};
      vecs[4] = '{0, 4, '{32'h00000000, 32'h80000000, 32'h3F800000, 32'h00000001}, 32'h00000000, 0, 0};
      vecs[5] = '{0, 4, '{32'hC0000000, 32'hC0400000, 32'hC0400000, 32'h40000000}, 32'hC0400000, 0, 1};
      vecs[6] = '{1, 1, '{32'h7FC00000, 32'h0, 32'h0, 32'h0}, QNAN, 1, 0};
      vecs[7] = '{1, 3, '{32'hBF800000, 32'hFF800000, 32'hC1000000, 32'h0}, 32'hBF800000, 0, 0};

      rst = 1'b1; start = 1'b0; len = '0; op_max = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset busy", 32'(busy), 32'd0);
      check("reset in_ready", 32'(in_ready), 32'd0);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset out_nan", 32'(out_nan), 32'd0);
      check("reset out_data", out_data, 32'd0);
`ifdef FMINMAX_INDEX_EN
      check("reset res_idx", 32'(res_idx), 32'd0);
`endif
      rst = 1'b0;

      // Directed vector table.
      for (int v = 0; v < 8; v++) begin
         elems.delete();
         for (int i = 0; i < vecs[v].n; i++) elems.push_back(vecs[v].d[i]);
         run_op($sformatf("vec%0d", v), vecs[v].op, vecs[v].n, 1'b0, 0, 1'b0,
                vecs[v].exp_data, vecs[v].exp_nan, vecs[v].exp_idx);
      end

      // Zero-length reduction completes immediately with a zero result.
      elems.delete();
      run_op("len0", 1'b1, 0, 1'b0, 0, 1'b0, 32'h0, 1'b0, 0);

      // Gappy input, stalled output, start pulses during DONE and at handshake.
      elems.delete();
      elems.push_back(32'h41200000);
      elems.push_back(32'hC1200000);
      elems.push_back(32'h3F000000);
      run_op("stall", 1'b0, 3, 1'b1, 5, 1'b1, 32'hC1200000, 1'b0, 1);

      // Reset in the middle of a reduction, after a NaN has been absorbed.
      @(posedge clk); #1;
      start = 1'b1; op_max = 1'b1; len = LEN_W'(4);
      @(posedge clk); #1;
      start = 1'b0; in_valid = 1'b1; in_data = 32'h40000000;
      @(posedge clk); #1;
      in_data = 32'h7FC00000;
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("midrst busy", 32'(busy), 32'd0);
      check("midrst in_ready", 32'(in_ready), 32'd0);
      check("midrst out_valid", 32'(out_valid), 32'd0);
      check("midrst out_nan", 32'(out_nan), 32'd0);
      check("midrst out_data", out_data, 32'd0);
`ifdef FMINMAX_INDEX_EN
      check("midrst res_idx", 32'(res_idx), 32'd0);
`endif
      @(posedge clk); #1;
      rst = 1'b0;
      elems.delete();
      elems.push_back(32'h40A00000);
      elems.push_back(32'hC0A00000);
      run_op("after rst", 1'b1, 2, 1'b0, 0, 1'b0, 32'h40A00000, 1'b0, 0);

      // Randomized reductions, including over-length requests that saturate.
      for (int t = 0; t < 30; t++) begin
         bit op;
         int n;
         int n_eff;
         op = 1'($urandom % 2);
         n  = (t == 0) ? 70 : int'($urandom_range(0, 70));
         elems.delete();
         for (int i = 0; i < n; i++) begin
            int r;
            logic [31:0] w;
            r = int'($urandom % 40);
            if (r == 0)                w = {1'($urandom % 2), 8'hFF, 23'($urandom | 1)};
            else if (r < 4)            w = {1'($urandom % 2), 31'd0};
            else if (r < 8 && i > 0)   w = elems[$urandom % i];
            else                       w = {1'($urandom % 2), 8'(126 + $urandom % 4), 3'($urandom), 20'd0};
            elems.push_back(w);
         end
         n_eff = (n > MAX_LEN) ? MAX_LEN : n;
         model(op, n_eff, m_data, m_nan, m_idx);
         run_op($sformatf("rand%0d", t), op, n, 1'b1, int'($urandom % 4), 1'b0,
                m_data, m_nan, m_idx);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
